// File: rtl/coin_vend_ctrl.sv
// Two-coin vending controller: credit accumulation, dispense, change, cancel.
// Ports: clk, reset (async high), coin_a/coin_b (levels), cancel (level),
//        out (sale pulse), change_valid/change (return), credit, state.
module coin_vend_ctrl #(
    parameter int VAL_A    = 1,
    parameter int VAL_B    = 2,
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                cancel,
    output logic                out,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          state
);

    localparam int MAX_CREDIT = PRICE - 1 + VAL_A + VAL_B;

    // Credit can never wrap as long as the worst case fits the width.
    if (PRICE < 1 || MAX_CREDIT > (2 ** CREDIT_W) - 1) begin : g_bad_params
        $error("coin_vend_ctrl: PRICE/VAL_A/VAL_B do not fit CREDIT_W");
    end

    localparam logic [CREDIT_W-1:0] VAL_A_C = CREDIT_W'(VAL_A);
    localparam logic [CREDIT_W-1:0] VAL_B_C = CREDIT_W'(VAL_B);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCUM    = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3
    } state_t;

    state_t              st;
    state_t              st_n;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_n;
    logic [CREDIT_W-1:0] change_q;
    logic [CREDIT_W-1:0] change_n;
    logic [CREDIT_W-1:0] add;
    logic [CREDIT_W-1:0] nc;
    logic                a_q;
    logic                b_q;
    logic                rise_a;
    logic                rise_b;

    // Coins are levels; only the rising edge adds credit.
    always_comb begin
        rise_a = coin_a & ~a_q;
        rise_b = coin_b & ~b_q;
        add    = (rise_a ? VAL_A_C : '0) + (rise_b ? VAL_B_C : '0);
        nc     = credit_q + add;
    end

    always_comb begin
        st_n     = IDLE;
        credit_n = credit_q;
        change_n = change_q;
        case (st)
            IDLE, ACCUM: begin
                // Cancel only matters when there is credit to give back;
                // coins arriving in the same cycle are dropped.
                if (st == ACCUM && cancel && credit_q != '0) begin
                    change_n = credit_q;
                    credit_n = '0;
                    st_n     = CHANGE;
                end else begin
                    credit_n = nc;
                    if (nc >= PRICE_C) begin
                        st_n = DISPENSE;
                    end else if (nc != '0) begin
                        st_n = ACCUM;
                    end else begin
                        st_n = IDLE;
                    end
                end
            end
            DISPENSE: begin
                // Change register is always rewritten, even with nothing owed.
                change_n = credit_q - PRICE_C;
                credit_n = '0;
                st_n     = (credit_q > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                st_n = IDLE;
            end
            default: begin
                st_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            credit_q <= '0;
            change_q <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
        end else begin
            st       <= st_n;
            credit_q <= credit_n;
            change_q <= change_n;
            // Edge trackers run in every state so held coins never re-count.
            a_q      <= coin_a;
            b_q      <= coin_b;
        end
    end

    assign out          = (st == DISPENSE);
    assign change_valid = (st == CHANGE);
    assign change       = change_q;
    assign credit       = credit_q;
    assign state        = st;

endmodule
